// File: rtl/uart_pkg.sv
// Shared UART definitions: frame states, parity codes and elaboration helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } status_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Bits needed to hold 0..v-1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Legal framing: at least 2 clocks per bit, 5..9 data bits, known parity, 1 or 2 stops.
  function automatic bit cfg_ok(input int bit_clocks, input int data_bits,
                                input int parity, input int stop_bits);
    return (bit_clocks >= 2) && (data_bits >= 5) && (data_bits <= 9) &&
           (parity >= PARITY_NONE) && (parity <= PARITY_ODD) &&
           ((stop_bits == 1) || (stop_bits == 2));
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts clocks within one serial bit and flags the last one.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int BIT_CLOCKS = 434
) (
  input  logic clk,
  input  logic clear,
  input  logic run,
  output logic bit_end
);

  localparam int W = clog2(BIT_CLOCKS);
  localparam logic [W-1:0] LAST = W'(BIT_CLOCKS - 1);

  logic [W-1:0] bit_clk_cnt;

  assign bit_end = (bit_clk_cnt == LAST);

  // Count 0..BIT_CLOCKS-1 while running, wrap on the last clock, hold at 0 when cleared.
  always_ff @(posedge clk) begin
    if (clear)
      bit_clk_cnt <= '0;
    else if (run)
      bit_clk_cnt <= bit_end ? '0 : bit_clk_cnt + W'(1);
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with valid/ready input and back-to-back framing.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_KHz  = 50000,
  parameter int BAUD_RATE_BPS = 115200,
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 data_valid,
  input  logic [DATA_BITS-1:0] data,
  output logic                 data_ready,
  output logic                 tx,
  output logic                 tx_en,
  output logic                 tx_done
);

  localparam int BIT_CLOCKS = (CLK_FREQ_KHz * 1000) / BAUD_RATE_BPS;
  localparam int DW = clog2(DATA_BITS);
  localparam logic [DW-1:0] DATA_LAST = DW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  if (!cfg_ok(BIT_CLOCKS, DATA_BITS, PARITY, STOP_BITS)) begin : g_bad_cfg
    $error("uart_tx_cfg: illegal configuration");
  end

  status_t                state, state_nxt;
  logic [DATA_BITS-1:0]   shift_data, shift_nxt;
  logic                   par_bit, par_nxt;
  logic [DW-1:0]          data_cnt, data_cnt_nxt;
  logic                   stop_cnt, stop_cnt_nxt;
  logic                   tx_nxt, en_nxt, done_nxt;
  logic                   bit_end, last_stop_end, xfer;

  uart_bit_timer #(.BIT_CLOCKS(BIT_CLOCKS)) u_bit_timer (
    .clk     (clk),
    .clear   (rst || (state == S_IDLE)),
    .run     (state != S_IDLE),
    .bit_end (bit_end)
  );

  assign last_stop_end = (state == S_STOP) && (stop_cnt == STOP_LAST) && bit_end;
  assign data_ready    = !rst && ((state == S_IDLE) || last_stop_end);
  assign xfer          = data_valid && data_ready;

  // Next-state, shifter/counter updates and the registered line values they imply.
  always_comb begin
    state_nxt    = state;
    shift_nxt    = shift_data;
    par_nxt      = par_bit;
    data_cnt_nxt = data_cnt;
    stop_cnt_nxt = stop_cnt;
    done_nxt     = 1'b0;

    case (state)
      S_START: if (bit_end) state_nxt = S_DATA;
      S_DATA: begin
        if (bit_end) begin
          shift_nxt = shift_data >> 1;
          if (data_cnt == DATA_LAST) begin
            data_cnt_nxt = '0;
            state_nxt    = (PARITY != PARITY_NONE) ? S_PARITY : S_STOP;
          end else begin
            data_cnt_nxt = data_cnt + DW'(1);
          end
        end
      end
      S_PARITY: if (bit_end) state_nxt = S_STOP;
      S_STOP: begin
        if (last_stop_end) begin
          done_nxt     = 1'b1;
          stop_cnt_nxt = 1'b0;
          state_nxt    = S_IDLE;
        end else if (bit_end) begin
          stop_cnt_nxt = 1'b1;
        end
      end
      default: ;
    endcase

    // A transfer (from Idle or the final stop clock) always starts a fresh frame.
    if (xfer) begin
      state_nxt    = S_START;
      shift_nxt    = data;
      par_nxt      = (PARITY == PARITY_ODD) ? ~(^data) : ^data;
      data_cnt_nxt = '0;
      stop_cnt_nxt = 1'b0;
    end

    case (state_nxt)
      S_START:  tx_nxt = 1'b0;
      S_DATA:   tx_nxt = shift_nxt[0];
      S_PARITY: tx_nxt = par_nxt;
      default:  tx_nxt = 1'b1;
    endcase
    en_nxt = (state_nxt != S_IDLE);
  end

  // State and output registers; reset abandons any frame without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      shift_data <= '0;
      par_bit    <= 1'b0;
      data_cnt   <= '0;
      stop_cnt   <= 1'b0;
      tx         <= 1'b1;
      tx_en      <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      state      <= state_nxt;
      shift_data <= shift_nxt;
      par_bit    <= par_nxt;
      data_cnt   <= data_cnt_nxt;
      stop_cnt   <= stop_cnt_nxt;
      tx         <= tx_nxt;
      tx_en      <= en_nxt;
      tx_done    <= done_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: four framings side by side, each checked every cycle
// against a queue of expected line values built from the frame definition.
module tb_uart_tx_cfg;

  localparam int NCH = 4;
  localparam int BC  = 4;  // 1 kHz / 250 bps

  function automatic int db_of(input int g); return (g == 1 || g == 2) ? 7 : 8; endfunction
  function automatic int pa_of(input int g); return (g == 1) ? 1 : (g == 2) ? 2 : 0; endfunction
  function automatic int sb_of(input int g); return (g == 3) ? 2 : 1; endfunction

  logic           clk = 1'b0;
  logic [NCH-1:0] rst;
  logic [NCH-1:0] dv;
  logic [8:0]     dat [NCH];
  logic [NCH-1:0] rdy, tx, txe, txd;
  bit             mon_on = 1'b0;
  int             n_vec = 0;
  int             n_err = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int ch, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s ch%0d t=%0t got %b expected %b", tag, ch, $time, act, exp);
    end
  endtask

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    localparam int DB = db_of(g);
    localparam int PA = pa_of(g);
    localparam int SB = sb_of(g);
    int acc_cnt = 0;

    uart_tx_cfg #(
      .CLK_FREQ_KHz (1),
      .BAUD_RATE_BPS(250),
      .DATA_BITS    (DB),
      .PARITY       (PA),
      .STOP_BITS    (SB)
    ) u_dut (
      .clk        (clk),
      .rst        (rst[g]),
      .data_valid (dv[g]),
      .data       (dat[g][DB-1:0]),
      .data_ready (rdy[g]),
      .tx         (tx[g]),
      .tx_en      (txe[g]),
      .tx_done    (txd[g])
    );

    // Reference: q holds the expected tx value of every remaining frame cycle,
    // head = the current cycle. Ready while idle or in a frame's final cycle.
    initial begin
      bit q[$];
      bit done_exp;
      bit rdy_m;
      bit par;
      logic [8:0] w;
      done_exp = 1'b0;
      forever begin
        @(posedge clk);
        rdy_m = !rst[g] && (q.size() <= 1);
        if (rst[g]) begin
          q.delete();
          done_exp = 1'b0;
        end else begin
          done_exp = 1'b0;
          if (q.size() > 0) begin
            void'(q.pop_front());
            done_exp = (q.size() == 0);
          end
          if (dv[g] && rdy_m) begin
            acc_cnt++;
            w   = dat[g];
            par = 1'b0;
            for (int i = 0; i < DB; i++) par ^= w[i];
            if (PA == 2) par = !par;
            repeat (BC) q.push_back(1'b0);
            for (int i = 0; i < DB; i++) repeat (BC) q.push_back(w[i]);
            if (PA != 0) repeat (BC) q.push_back(par);
            repeat (SB * BC) q.push_back(1'b1);
          end
        end
        @(negedge clk);
        if (mon_on) begin
          chk("tx",         g, tx[g],  (q.size() > 0) ? q[0] : 1'b1);
          chk("tx_en",      g, txe[g], q.size() > 0);
          chk("tx_done",    g, txd[g], done_exp);
          chk("data_ready", g, rdy[g], !rst[g] && (q.size() <= 1));
        end
      end
    end
  end

  function automatic int get_acc(input int i);
    case (i)
      0:       return g_ch[0].acc_cnt;
      1:       return g_ch[1].acc_cnt;
      2:       return g_ch[2].acc_cnt;
      default: return g_ch[3].acc_cnt;
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one word per channel and hold valid until each channel has taken it.
  task automatic send(input logic [8:0] w0, input logic [8:0] w1,
                      input logic [8:0] w2, input logic [8:0] w3);
    int base [NCH];
    logic [NCH-1:0] pend;
    dat[0] = w0; dat[1] = w1; dat[2] = w2; dat[3] = w3;
    for (int i = 0; i < NCH; i++) base[i] = get_acc(i);
    pend = '1;
    dv   = pend;
    for (int c = 0; c < 200 && pend != '0; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NCH; i++) if (get_acc(i) != base[i]) pend[i] = 1'b0;
      dv = pend;
    end
    dv = '0;
    for (int i = 0; i < NCH; i++) chk("accept_wait", i, !pend[i], 1'b1);
  endtask

  initial begin
    rst = '1;
    dv  = '0;
    for (int i = 0; i < NCH; i++) dat[i] = '0;
    @(posedge clk);
    #1;
    mon_on = 1'b1;
    idle(2);
    rst = '0;
    idle(2);

    // Single frames: 8N1 0xA5, 7E1/7O1 0x55, 8N2 0x00.
    send(9'h0A5, 9'h055, 9'h055, 9'h000);
    idle(50);

    // Back-to-back with valid held high.
    send(9'h001, 9'h001, 9'h001, 9'h001);
    send(9'h080, 9'h080, 9'h080, 9'h080);
    idle(60);

    // Reset during data bit 3, with a word offered in the reset cycle.
    send(9'h0FF, 9'h0FF, 9'h0FF, 9'h0FF);
    repeat (17) @(posedge clk);
    #1;
    rst = '1;
    dv  = '1;
    for (int i = 0; i < NCH; i++) dat[i] = 9'h03C;
    @(posedge clk);
    #1;
    rst = '0;
    dv  = '0;
    idle(2);
    send(9'h03C, 9'h03C, 9'h03C, 9'h03C);
    idle(50);

    // Valid toggling and data churn while busy.
    send(9'h05A, 9'h02B, 9'h06C, 9'h0F0);
    for (int c = 0; c < 30; c++) begin
      dv = NCH'($urandom);
      for (int i = 0; i < NCH; i++) dat[i] = 9'($urandom);
      idle(1);
    end
    dv = '0;
    idle(60);

    // Random traffic with occasional resets.
    for (int c = 0; c < 2500; c++) begin
      for (int i = 0; i < NCH; i++) begin
        rst[i] = ($urandom_range(0, 149) == 0);
        dv[i]  = ($urandom_range(0, 2) == 0);
        dat[i] = 9'($urandom);
      end
      idle(1);
    end
    rst = '0;
    dv  = '0;
    idle(80);
    mon_on = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Configurable UART transmitter, the next-generation successor to the fixed 8N1 transmitter. It is parametrised in data width, parity mode and stop-bit count, and uses a valid/ready handshake. Back-to-back frames can be sent with no idle gap. It sits between a byte/word producer (FIFO or CPU register) and the serial pin, and drives `tx`, `tx_en` and a per-frame `tx_done` pulse.

## Interface
- `CLK_FREQ_KHz`, 50000: system clock frequency in kHz.
- `BAUD_RATE_BPS`, 115200: serial bit rate.
- `BIT_CLOCKS`, derived as (CLK_FREQ_KHz*1000)/BAUD_RATE_BPS: clocks per serial bit. Elaboration fails if it is below 2.
- `DATA_BITS`, 8: payload bits per frame, legal range 5..9.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: stop bits per frame, 1 or 2.
- `clk` in 1: single system clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `data_valid` in 1: producer has a word on `data`.
- `data` in DATA_BITS: payload, sent LSB first.
- `data_ready` out 1: block accepts `data` this cycle.
- `tx` out 1: serial line, idle high.
- `tx_en` out 1: high while a frame is on the line (start bit through last stop bit).
- `tx_done` out 1: one-cycle pulse marking the end of each frame.

## Operation
- States:
  - `Idle`
  - `StartBit`
  - `DataBits`
  - `ParityBit` (skipped when PARITY=0)
  - `StopBit`
- Counters:
  - `bitClkCnt` has width clog2(BIT_CLOCKS) and counts 0..BIT_CLOCKS-1. `bitEnd` = (bitClkCnt == BIT_CLOCKS-1).
  - `dataBitCnt` has width clog2(DATA_BITS) and counts 0..DATA_BITS-1.
  - `stopCnt` is 1 bit.
- Acceptance:
  - Transfer happens when `data_valid && data_ready` at a rising edge.
  - On transfer, `data` is latched into `shiftData` and the parity bit is latched.
  - Even parity bit = XOR of data bits. Odd parity bit = its inverse.
- `data_ready` is combinational and equals `!rst && (state==Idle || lastStopEnd)`. Here `lastStopEnd` = state==StopBit && stopCnt==STOP_BITS-1 && bitEnd.
- Transitions:
  - `Idle` → `StartBit` on transfer.
  - `StartBit` → `DataBits` on bitEnd.
  - `DataBits`: on bitEnd, shift `shiftData` right by 1. When dataBitCnt==DATA_BITS-1, go to `ParityBit`, or to `StopBit` if PARITY=0.
  - `ParityBit` → `StopBit` on bitEnd.
  - `StopBit`: on bitEnd with stopCnt<STOP_BITS-1, increment `stopCnt`. On `lastStopEnd`, go to `StartBit` if a transfer occurs in that cycle, otherwise go to `Idle`.
- Line value `tx` per state:
  - `Idle`: 1
  - `StartBit`: 0
  - `DataBits`: shiftData[0]
  - `ParityBit`: latched parity
  - `StopBit`: 1
- `data` changes while not accepted are ignored. `data_valid` is not required to stay high.

## Timing
- Reset values: `tx`=1, `tx_en`=0, `tx_done`=0, `data_ready`=0 while `rst` is high, state=`Idle`, all counters 0.
- `tx`, `tx_en` and `tx_done` are registered.
- Latency:
  - Transfer at edge T.
  - The start bit appears on `tx` from T+1 and lasts BIT_CLOCKS cycles.
  - Frame length = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × BIT_CLOCKS cycles.
- `tx_done` is high for exactly one cycle, the first cycle after the final stop bit ends. This holds even when the next frame starts back-to-back.
- Back-to-back: the next start bit follows the last stop-bit cycle immediately. There is no extra idle cycle, and `tx_en` stays high throughout.
- Reset mid-frame:
  - The frame is abandoned and `tx` returns to 1 on the next edge.
  - No `tx_done` pulse is issued.
  - A word accepted in the same cycle as reset is discarded (`data_ready` is 0 then).
- `data_valid` in any cycle where `data_ready`=0 has no effect.

## Structure
- Shared package `uart_pkg`:
  - `Status` enum: Idle, StartBit, DataBits, ParityBit, StopBit.
  - `Parity` constants: NONE=0, EVEN=1, ODD=2.
  - `clog2` function.
  - Parameter-legality checks.
- Sub-module `uart_bit_timer`:
  - Holds the `bitClkCnt` counter.
  - Takes `clear` and `run` inputs and produces the `bitEnd` output.
  - The future `uart_rx_cfg` will reuse it.
- Everything else lives in one `always` block inside `uart_tx_cfg`.

## Test plan
Bench uses CLK_FREQ_KHz=1 and BAUD_RATE_BPS=250, giving BIT_CLOCKS=4.
- **Default 8N1**, send 0xA5 → `tx` sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles. `tx_en` is high for 40 cycles and `tx_done` pulses once at cycle 41 after acceptance.
- **DATA_BITS=7, PARITY=EVEN**, send 0x55 (four ones) → parity bit 0. **PARITY=ODD**, same word → parity bit 1. Frame lasts 40 cycles.
- **STOP_BITS=2, PARITY=NONE**, send 0x00 → 8 cycles of `tx`=1 after the data bits. `data_ready` rises only in the last of those cycles.
- **Back-to-back**, `data_valid` held high with 0x01 then 0x80 → second start bit directly follows the first frame's stop bit with no gap. `tx_en` never drops and `tx_done` pulses twice.
- **Reset mid-frame**, `rst` asserted during data bit 3 for 1 cycle → next cycle `tx`=1 and `tx_en`=0, no `tx_done`. A following 0x3C transmits correctly.
- **Handshake**, toggle `data_valid` while busy → no extra frame is sent. `data` changes mid-frame do not alter the bits on the line.
